// File: rtl/pcileech_ft601_rx_pkg.sv
// Shared types for the FT601 read engine: FSM state encoding and byte-enable constant.
package pcileech_ft601_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TURN,
    READ,
    DRAIN
  } rx_state_e;

  localparam logic [3:0] FT601_BE_FULL = 4'hF;

endpackage

// File: rtl/pcileech_ft601_rx_skidfifo.sv
// Circular skid FIFO with an extra pointer MSB to tell full from empty.
module pcileech_ft601_rx_skidfifo
  import pcileech_ft601_rx_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [AW:0]      count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
  assign count_o = wr_ptr_q - rd_ptr_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Empty FIFO presents zero so dout has a defined value out of reset.
  assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/pcileech_ft601_rx.sv
// FT601 245-sync read engine: drains host data into a skid FIFO with valid/ready output.
// Optional byte-enable filter (drop partial words, count them) under FT601_RX_BE_FILTER_EN.
module pcileech_ft601_rx
  import pcileech_ft601_rx_pkg::*;
#(
  parameter int unsigned SKID_DEPTH = 8,
  parameter int unsigned SKID_SLACK = 3
) (
  input  logic        ft601_clk,
  input  logic        rst,
  input  logic        ft601_rxf_n,
  input  logic [31:0] ft601_data_in,
  input  logic [3:0]  ft601_be_in,
  input  logic        tx_busy,
  output logic        ft601_oe_n,
  output logic        ft601_rd_n,
  output logic        rx_active,
  output logic [31:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [15:0] err_cnt
);

  localparam int unsigned AW = $clog2(SKID_DEPTH);
  localparam logic [AW:0] SPACE_MAX = (AW+1)'(SKID_DEPTH - SKID_SLACK);

  logic        rxf_q;
  logic [31:0] data_q;
  logic [3:0]  be_q;
  logic        rd_n_d1_q;

  rx_state_e   state_q;
  logic        drain_q;
  logic        oe_n_q, rd_n_q, rx_active_q;

  logic        capture, push, pop;
  logic        fifo_full, fifo_empty;
  logic [AW:0] fifo_count;
  logic        space_ok;

  always_ff @(posedge ft601_clk or posedge rst) begin
    if (rst) begin
      rxf_q     <= 1'b1;
      data_q    <= '0;
      be_q      <= '0;
      rd_n_d1_q <= 1'b1;
    end else begin
      rxf_q     <= ft601_rxf_n;
      data_q    <= ft601_data_in;
      be_q      <= ft601_be_in;
      rd_n_d1_q <= rd_n_q;
    end
  end

  // A word is valid when the strobe was low in the same cycle the pads were sampled.
  assign capture  = !rd_n_d1_q && !rxf_q;
  assign space_ok = (fifo_count <= SPACE_MAX);
  assign pop      = dout_valid && dout_ready;

`ifdef FT601_RX_BE_FILTER_EN
  logic [15:0] err_cnt_q;
  logic        drop;

  assign drop = capture && (be_q != FT601_BE_FULL);
  assign push = capture && (be_q == FT601_BE_FULL);

  always_ff @(posedge ft601_clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (drop && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_be;

  assign unused_be = ^be_q;
  assign push      = capture;
  assign err_cnt   = '0;
`endif

  // Pin registers are updated together with the state, so each pin moves on the transition edge.
  always_ff @(posedge ft601_clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      drain_q     <= 1'b0;
      oe_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      rx_active_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!rxf_q && !tx_busy && space_ok) begin
            state_q     <= TURN;
            oe_n_q      <= 1'b0;
            rx_active_q <= 1'b1;
          end
        end
        TURN: begin
          state_q <= READ;
          rd_n_q  <= 1'b0;
        end
        READ: begin
          if (rxf_q || !space_ok) begin
            state_q <= DRAIN;
            rd_n_q  <= 1'b1;
            drain_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (drain_q) begin
            state_q     <= IDLE;
            oe_n_q      <= 1'b1;
            rx_active_q <= 1'b0;
          end else begin
            drain_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign ft601_oe_n = oe_n_q;
  assign ft601_rd_n = rd_n_q;
  assign rx_active  = rx_active_q;
  assign dout_valid = !fifo_empty;

  pcileech_ft601_rx_skidfifo #(
    .DEPTH (SKID_DEPTH),
    .WIDTH (32)
  ) u_skid (
    .clk_i   (ft601_clk),
    .rst_i   (rst),
    .push_i  (push),
    .din_i   (data_q),
    .pop_i   (pop),
    .dout_o  (dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  a_no_overflow : assert property (@(posedge ft601_clk) disable iff (rst) !(push && fifo_full));

endmodule

// File: tb/tb_pcileech_ft601_rx.sv
// Bench for pcileech_ft601_rx: FT601 host model, transfer scoreboard and directed scenarios.
module tb_pcileech_ft601_rx;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  be;
  } hw_t;

  typedef struct {
    logic [31:0] data;
    int          at;
  } ew_t;

  logic        ft601_clk = 1'b0;
  logic        rst = 1'b1;
  logic        ft601_rxf_n = 1'b1;
  logic [31:0] ft601_data_in = 32'hDEADBEEF;
  logic [3:0]  ft601_be_in = 4'h0;
  logic        tx_busy = 1'b0;
  logic        dout_ready = 1'b0;
  logic        ft601_oe_n, ft601_rd_n, rx_active, dout_valid;
  logic [31:0] dout;
  logic [15:0] err_cnt;

  hw_t         host_q[$];
  ew_t         exp_q[$];
  int          bad_q[$];
  logic [31:0] got[$];
  int          cyc = 0;
  logic        rd_s = 1'b0;
  logic [15:0] err_exp = '0;
  int          total = 0;
  int          bad = 0;

  pcileech_ft601_rx #(
    .SKID_DEPTH (8),
    .SKID_SLACK (3)
  ) dut (
    .ft601_clk     (ft601_clk),
    .rst           (rst),
    .ft601_rxf_n   (ft601_rxf_n),
    .ft601_data_in (ft601_data_in),
    .ft601_be_in   (ft601_be_in),
    .tx_busy       (tx_busy),
    .ft601_oe_n    (ft601_oe_n),
    .ft601_rd_n    (ft601_rd_n),
    .rx_active     (rx_active),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .dout_ready    (dout_ready),
    .err_cnt       (err_cnt)
  );

  always #5 ft601_clk = ~ft601_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // FT601 host side: one word leaves its FIFO on each edge where oe_n and rd_n were low.
  always @(posedge ft601_clk) begin
    hw_t w;
    logic keep;
    cyc++;
    if (!rst && rd_s && host_q.size() > 0) begin
      w = host_q.pop_front();
`ifdef FT601_RX_BE_FILTER_EN
      keep = (w.be == 4'hF);
`else
      keep = 1'b1;
`endif
      if (keep) exp_q.push_back('{data: w.data, at: cyc});
      else bad_q.push_back(cyc);
    end
    #1;
    if (host_q.size() > 0) begin
      ft601_rxf_n   = 1'b0;
      ft601_data_in = host_q[0].data;
      ft601_be_in   = host_q[0].be;
    end else begin
      ft601_rxf_n   = 1'b1;
      ft601_data_in = 32'hDEADBEEF;
      ft601_be_in   = 4'h0;
    end
  end

  // A word transferred on edge E must be at the FIFO head from edge E+1 on.
  always @(negedge ft601_clk) begin
    logic exp_valid;
    rd_s = !ft601_rd_n && !ft601_oe_n;
    if (rst) begin
      chk("rst_oe_n", ft601_oe_n, 1);
      chk("rst_rd_n", ft601_rd_n, 1);
      chk("rst_rx_active", rx_active, 0);
      chk("rst_dout_valid", dout_valid, 0);
      chk("rst_dout", dout, 0);
      chk("rst_err_cnt", err_cnt, 0);
      exp_q.delete();
      bad_q.delete();
      err_exp = '0;
    end else begin
      while (bad_q.size() > 0 && bad_q[0] < cyc) begin
        bad_q.delete(0);
        if (err_exp != 16'hFFFF) err_exp++;
      end
      exp_valid = (exp_q.size() > 0) && (exp_q[0].at < cyc);
      chk("dout_valid", dout_valid, exp_valid);
      if (exp_valid) begin
        chk("dout", dout, exp_q[0].data);
        if (dout_ready) begin
          got.push_back(exp_q[0].data);
          exp_q.delete(0);
        end
      end
      chk("err_cnt", err_cnt, err_exp);
      chk("active_vs_oe", rx_active, !ft601_oe_n);
      chk("rd_needs_oe", ft601_rd_n | !ft601_oe_n, 1);
    end
  end

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (!(host_q.size() == 0 && exp_q.size() == 0 && bad_q.size() == 0 &&
             !rx_active && !dout_valid) && n < 400) begin
      @(negedge ft601_clk);
      n++;
    end
    chk(nm, n < 400, 1);
  endtask

  task automatic load(input logic [31:0] base, input int num);
    for (int i = 0; i < num; i++) host_q.push_back('{data: base + 32'(i), be: 4'hF});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) @(posedge ft601_clk);
    #2 rst = 1'b0;

    // T1: basic burst of 5 words, turnaround and latency
    dout_ready = 1'b1;
    load(32'h1, 5);
    k = 0;
    while (ft601_oe_n && k < 50) begin @(negedge ft601_clk); k++; end
    chk("t1_oe_low", ft601_oe_n, 0);
    chk("t1_turn_rd_high", ft601_rd_n, 1);
    @(negedge ft601_clk);
    chk("t1_read_rd_low", ft601_rd_n, 0);
    k = 0;
    while (!dout_valid && k < 10) begin @(negedge ft601_clk); k++; end
    chk("t1_latency", k, 2);
    wait_idle("t1_done");
    chk("t1_count", got.size(), 5);
    for (int i = 0; i < got.size(); i++) chk("t1_word", got[i], 32'(i + 1));

    // T2: backpressure, FIFO fills to exactly 8 then resumes
    got.delete();
    @(posedge ft601_clk); #2 dout_ready = 1'b0;
    load(32'h100, 20);
    k = 0;
    while (ft601_oe_n && k < 50) begin @(negedge ft601_clk); k++; end
    k = 0;
    while (!ft601_oe_n && k < 100) begin @(negedge ft601_clk); k++; end
    repeat (5) @(negedge ft601_clk);
    chk("t2_host_left", host_q.size(), 12);
    chk("t2_buffered", exp_q.size(), 8);
    chk("t2_stalled", rx_active, 0);
    @(posedge ft601_clk); #2 dout_ready = 1'b1;
    wait_idle("t2_done");
    chk("t2_count", got.size(), 20);
    for (int i = 0; i < got.size(); i++) chk("t2_word", got[i], 32'h100 + 32'(i));

    // T3: tx_busy holds the reader off
    got.delete();
    @(posedge ft601_clk); #2 tx_busy = 1'b1;
    load(32'h200, 4);
    repeat (6) begin
      @(negedge ft601_clk);
      chk("t3_oe_hold", ft601_oe_n, 1);
      chk("t3_rd_hold", ft601_rd_n, 1);
      chk("t3_active_hold", rx_active, 0);
    end
    @(posedge ft601_clk); #2 tx_busy = 1'b0;
    k = 0;
    while (ft601_oe_n && k < 10) begin @(negedge ft601_clk); k++; end
    chk("t3_start_within_2", k <= 2, 1);
    wait_idle("t3_done");
    chk("t3_count", got.size(), 4);

    // T4: rxf_n rises after 3 words, DRAIN keeps oe_n low 2 more cycles
    got.delete();
    load(32'h300, 3);
    k = 0;
    while (ft601_rd_n && k < 50) begin @(negedge ft601_clk); k++; end
    k = 0;
    while (!ft601_rd_n && k < 50) begin @(negedge ft601_clk); k++; end
    k = 0;
    while (!ft601_oe_n && k < 50) begin @(negedge ft601_clk); k++; end
    chk("t4_oe_after_rd", k, 2);
    wait_idle("t4_done");
    chk("t4_count", got.size(), 3);
    for (int i = 0; i < got.size(); i++) chk("t4_word", got[i], 32'h300 + 32'(i));

    // T5: reset in the middle of READ
    got.delete();
    @(posedge ft601_clk); #2 dout_ready = 1'b0;
    load(32'h400, 10);
    k = 0;
    while (ft601_rd_n && k < 50) begin @(negedge ft601_clk); k++; end
    repeat (3) @(negedge ft601_clk);
    chk("t5_pre_valid", dout_valid, 1);
    chk("t5_pre_rd_low", ft601_rd_n, 0);
    @(posedge ft601_clk); #3 rst = 1'b1;
    #1;
    chk("t5_async_oe", ft601_oe_n, 1);
    chk("t5_async_rd", ft601_rd_n, 1);
    chk("t5_async_valid", dout_valid, 0);
    host_q.delete();
    repeat (2) @(posedge ft601_clk);
    #2 rst = 1'b0;
    dout_ready = 1'b1;
    repeat (3) begin
      @(negedge ft601_clk);
      chk("t5_post_empty", dout_valid, 0);
    end

    // T6: byte-enable handling
    got.delete();
    host_q.push_back('{data: 32'hA1, be: 4'hF});
    host_q.push_back('{data: 32'hA2, be: 4'h3});
    host_q.push_back('{data: 32'hA3, be: 4'hF});
    wait_idle("t6_done");
    @(negedge ft601_clk);
`ifdef FT601_RX_BE_FILTER_EN
    chk("t6_count", got.size(), 2);
    chk("t6_w0", got[0], 32'hA1);
    chk("t6_w1", got[1], 32'hA3);
    chk("t6_err", err_cnt, 1);
`else
    chk("t6_count", got.size(), 3);
    chk("t6_w0", got[0], 32'hA1);
    chk("t6_w1", got[1], 32'hA2);
    chk("t6_w2", got[2], 32'hA3);
    chk("t6_err", err_cnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
